// File: rtl/spi_rx_pkg.sv
// Shared encodings and helpers for the SPI serial receive core.
// Frame-format codes, the maximum word width, and the df-to-width decode.
// Pure declarations: no logic, no latency, no backpressure.
package spi_rx_pkg;

    localparam int DW = 32;

    localparam logic [1:0] DF_8  = 2'b00;
    localparam logic [1:0] DF_16 = 2'b01;
    localparam logic [1:0] DF_32 = 2'b10;

    // The fourth code is a reserved alias of the 32-bit format.
    function automatic logic [5:0] df_width(input logic [1:0] df);
        case (df)
            DF_8:    df_width = 6'd8;
            DF_16:   df_width = 6'd16;
            default: df_width = 6'd32;
        endcase
    endfunction

endpackage

// File: rtl/spi_rx_crc.sv
// Serial, non-reflected CRC engine: one received bit per enabled clock, init 0.
// Latency: the register reflects a bit on the same edge that captures it.
// No backpressure: it is advanced purely by the gated receive clock.
module spi_rx_crc
    import spi_rx_pkg::*;
#(
    parameter int CW = DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [5:0]    width,
    input  logic [CW-1:0] poly,
    input  logic          data_bit,
    output logic [CW-1:0] crc
);

    logic [CW-1:0] mask;
    logic          fb;
    logic [CW-1:0] crc_nxt;

    // Keep only the low 'width' bits so narrow CRCs stay zero-extended.
    always_comb begin
        mask = '1;
        case (width)
            6'd8:    mask = CW'(32'h0000_00FF);
            6'd16:   mask = CW'(32'h0000_FFFF);
            default: mask = '1;
        endcase
    end

    // Feedback comes from the top bit of the active width, not of the register.
    always_comb begin
        fb      = crc[5'(width - 6'd1)] ^ data_bit;
        crc_nxt = (crc << 1) & mask;
        if (fb) begin
            crc_nxt = crc_nxt ^ (poly & mask);
        end
    end

    // CRC state register, only advanced while accumulation is enabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            crc <= '0;
        end else if (en) begin
            crc <= crc_nxt;
        end
    end

endmodule

// File: rtl/spi_rxc.sv
// SPI serial receive core: deserialises 8/16/32-bit frames, counts frames, runs an optional CRC.
// Latency: zero extra; the edge that samples the last bit also publishes the full word.
// No backpressure: runs off the gated rx clock, and every output holds while that clock is stopped.
module spi_rxc
    import spi_rx_pkg::*;
#(
    parameter int FCNT_W = 13,
    parameter int DW     = spi_rx_pkg::DW
) (
    input  logic              clk_rx,
    input  logic              spi_rx_rst,
    input  logic [1:0]        df,
    input  logic [FCNT_W-1:0] spi_tnum_max,
    input  logic              lsbf,
    input  logic              crc_en,
    input  logic              shift_in,
    input  logic [DW-1:0]     crc_poly,
    output logic [DW-1:0]     rx_crc_data_out,
    output logic [DW-1:0]     spi_rx_data,
    output logic              rx_num_max_en,
    output logic              rx_crc_en,
    output logic              rx_busy
);

    logic [5:0]        width;
    logic [4:0]        w_m1;
    logic [4:0]        bcnt;
    logic [4:0]        pos;
    logic              last;
    logic [DW-1:0]     sreg;
    logic [DW-1:0]     word_nxt;
    logic [FCNT_W-1:0] fcnt;
    logic              crc_run;

    assign width = df_width(df);
    assign w_m1  = 5'(width - 6'd1);
    assign last  = (bcnt == w_m1);
    assign pos   = lsbf ? bcnt : 5'(w_m1 - bcnt);

    // Merge the incoming bit into the word; bit 0 starts from a clean word so
    // stale bits from a previous frame never leak into this one.
    always_comb begin
        word_nxt      = (bcnt == 5'd0) ? '0 : sreg;
        word_nxt[pos] = shift_in;
    end

    // Shifter, bit counter and busy flag; the final bit publishes the word directly.
    always_ff @(posedge clk_rx) begin
        if (spi_rx_rst) begin
            bcnt        <= '0;
            sreg        <= '0;
            spi_rx_data <= '0;
            rx_busy     <= 1'b0;
        end else begin
            bcnt    <= last ? 5'd0 : bcnt + 5'd1;
            sreg    <= word_nxt;
            rx_busy <= !last;
            if (last) begin
                spi_rx_data <= word_nxt;
            end
        end
    end

    // Frame counter saturates at the programmed maximum; reaching it freezes
    // the counter and, when enabled, marks the CRC as final.
    always_ff @(posedge clk_rx) begin
        if (spi_rx_rst) begin
            fcnt          <= '0;
            rx_num_max_en <= 1'b0;
            rx_crc_en     <= 1'b0;
        end else if (last && !rx_num_max_en) begin
            if (fcnt == spi_tnum_max) begin
                rx_num_max_en <= 1'b1;
                rx_crc_en     <= crc_en;
            end else begin
                fcnt <= fcnt + 1'b1;
            end
        end
    end

    assign crc_run = crc_en && !rx_num_max_en;

    spi_rx_crc #(
        .CW (DW)
    ) u_crc (
        .clk      (clk_rx),
        .rst      (spi_rx_rst),
        .en       (crc_run),
        .width    (width),
        .poly     (crc_poly),
        .data_bit (shift_in),
        .crc      (rx_crc_data_out)
    );

endmodule

// File: tb/tb_spi_rxc.sv
// Directed bench for spi_rxc with a scoreboard queue of expected words and a reference CRC/frame model.
// Each bit is driven while the clock is low, then one rising edge; outputs are sampled with the clock low.
// The clock is only pulsed while bits are sent, mimicking the gated SPI receive clock.
module tb_spi_rxc;

    logic        clk_rx = 1'b0;
    logic        spi_rx_rst = 1'b0;
    logic [1:0]  df = 2'b00;
    logic [12:0] spi_tnum_max = '0;
    logic        lsbf = 1'b0;
    logic        crc_en = 1'b0;
    logic        shift_in = 1'b0;
    logic [31:0] crc_poly = '0;
    logic [31:0] rx_crc_data_out;
    logic [31:0] spi_rx_data;
    logic        rx_num_max_en;
    logic        rx_crc_en;
    logic        rx_busy;

    int tests = 0;
    int fails = 0;

    logic [31:0] exp_q[$];
    logic [31:0] m_crc;
    int          m_fcnt;
    logic        m_max;

    spi_rxc dut (
        .clk_rx          (clk_rx),
        .spi_rx_rst      (spi_rx_rst),
        .df              (df),
        .spi_tnum_max    (spi_tnum_max),
        .lsbf            (lsbf),
        .crc_en          (crc_en),
        .shift_in        (shift_in),
        .crc_poly        (crc_poly),
        .rx_crc_data_out (rx_crc_data_out),
        .spi_rx_data     (spi_rx_data),
        .rx_num_max_en   (rx_num_max_en),
        .rx_crc_en       (rx_crc_en),
        .rx_busy         (rx_busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One rising edge followed by the falling edge; returns with clk low.
    task automatic pulse();
        #5 clk_rx = 1'b1;
        #5 clk_rx = 1'b0;
    endtask

    task automatic do_reset(input int n);
        spi_rx_rst = 1'b1;
        shift_in   = 1'b1;
        for (int i = 0; i < n; i++) begin
            pulse();
            check("rst_data", spi_rx_data, 32'h0);
            check("rst_busy", {31'h0, rx_busy}, 32'h0);
            check("rst_crc", rx_crc_data_out, 32'h0);
            check("rst_max", {31'h0, rx_num_max_en}, 32'h0);
            check("rst_crcen", {31'h0, rx_crc_en}, 32'h0);
        end
        spi_rx_rst = 1'b0;
        shift_in   = 1'b0;
        m_crc  = '0;
        m_fcnt = 0;
        m_max  = 1'b0;
    endtask

    // Drive one frame bit by bit, checking busy per edge, then pop the scoreboard.
    task automatic send_frame(input logic [31:0] word, input int w);
        logic [31:0] mask;
        logic        b;
        logic        fb;
        logic [31:0] got;
        mask = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
        exp_q.push_back(word & mask);
        for (int k = 0; k < w; k++) begin
            b = lsbf ? word[k] : word[w-1-k];
            shift_in = b;
            if (crc_en && !m_max) begin
                fb    = m_crc[w-1] ^ b;
                m_crc = (m_crc << 1) & mask;
                if (fb) m_crc = m_crc ^ (crc_poly & mask);
            end
            pulse();
            if (k < w - 1) check("busy_mid", {31'h0, rx_busy}, 32'h1);
            else           check("busy_end", {31'h0, rx_busy}, 32'h0);
        end
        if (!m_max) begin
            if (m_fcnt == int'(spi_tnum_max)) m_max = 1'b1;
            else m_fcnt++;
        end
        got = exp_q.pop_front();
        check("rx_data", spi_rx_data, got);
        check("crc_val", rx_crc_data_out, m_crc);
        check("num_max", {31'h0, rx_num_max_en}, {31'h0, m_max});
        check("crc_en_out", {31'h0, rx_crc_en}, {31'h0, m_max & crc_en});
    endtask

    initial begin
        m_crc  = '0;
        m_fcnt = 0;
        m_max  = 1'b0;

        // 8-bit MSB-first, one of two frames
        df = 2'b00; lsbf = 1'b0; spi_tnum_max = 13'd1; crc_en = 1'b0;
        do_reset(1);
        send_frame(32'h0000_00A5, 8);

        // 16-bit LSB-first
        df = 2'b01; lsbf = 1'b1; spi_tnum_max = 13'd1;
        do_reset(1);
        send_frame(32'h0000_B971, 16);

        // 32-bit MSB-first, busy checked on every edge
        df = 2'b10; lsbf = 1'b0; spi_tnum_max = 13'd1;
        do_reset(1);
        send_frame(32'hC3D2_F1E8, 32);

        // CRC-8 over four frames; last frame hits the maximum
        df = 2'b00; lsbf = 1'b0; spi_tnum_max = 13'd3; crc_en = 1'b1; crc_poly = 32'h07;
        do_reset(1);
        send_frame(32'hA1, 8);
        check("crc_a1_const", rx_crc_data_out, 32'h6E);
        send_frame(32'hB2, 8);
        send_frame(32'hC3, 8);
        send_frame(32'hD4, 8);
        // After the maximum: data still updates, CRC frozen, flags sticky
        send_frame(32'h99, 8);

        // Reserved df alias behaves as 32-bit, LSB-first with CRC
        df = 2'b11; lsbf = 1'b1; spi_tnum_max = 13'd0; crc_en = 1'b1; crc_poly = 32'h04C1_1DB7;
        do_reset(1);
        send_frame(32'h1234_5678, 32);

        // tnum_max=0 without CRC
        df = 2'b00; lsbf = 1'b0; spi_tnum_max = 13'd0; crc_en = 1'b0; crc_poly = 32'h07;
        do_reset(1);
        send_frame(32'h3C, 8);

        // Reset mid-frame (data bit present on reset edges), then a clean frame
        spi_tnum_max = 13'd3;
        do_reset(1);
        for (int i = 0; i < 5; i++) begin
            shift_in = 1'b1;
            pulse();
        end
        check("partial_busy", {31'h0, rx_busy}, 32'h1);
        do_reset(2);
        send_frame(32'h5A, 8);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
